spike_axi_mem_slave: RTL



---
 rtl/spike_axi_mem_slave.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spike_axi_mem_slave.sv
// spike_axi_mem_slave: single-port AXI slave memory behind the Spike agent's AXI master.
// Accepts single-beat, 32-bit, word-aligned reads and writes; byte-strobe writes.
// Optional: define SPIKE_MEM_WAIT_EN to insert WAIT_CYCLES idle cycles before BVALID/RVALID.
module spike_axi_mem_slave #(
   parameter int unsigned MEM_POWER_SIZE = 12,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = MEM_POWER_SIZE,
   parameter int unsigned AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int unsigned WAIT_CYCLES    = 3
) (
   input  logic                      CPUNC_ACLK,
   input  logic                      CPUNC_ARESET,
   input  logic [7:0]                CPUNC_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
   input  logic [1:0]                CPUNC_AWSIZE,
   input  logic                      CPUNC_AWVALID,
   output logic                      CPUNC_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
   input  logic [AXI_MASK_WIDTH-1:0] CPUNC_WSTRB,
   input  logic                      CPUNC_WLAST,
   input  logic                      CPUNC_WVALID,
   output logic                      CPUNC_WREADY,
   output logic [7:0]                CPUNC_BID,
   output logic                      CPUNC_BRESP,
   output logic                      CPUNC_BVALID,
   input  logic                      CPUNC_BREADY,
   input  logic [7:0]                CPUNC_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
   input  logic [1:0]                CPUNC_ARSIZE,
   input  logic                      CPUNC_ARVALID,
   output logic                      CPUNC_ARREADY,
   output logic [7:0]                CPUNC_RID,
   output logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
   output logic                      CPUNC_RRESP,
   output logic                      CPUNC_RLAST,
   output logic                      CPUNC_RVALID,
   input  logic                      CPUNC_RREADY
);

   localparam int unsigned IdxW  = MEM_POWER_SIZE - 2;
   localparam int unsigned Words = 2 ** IdxW;

   typedef enum logic [2:0] {
      W_IDLE,
      W_HAVE_A,
      W_HAVE_D,
      W_RESP
`ifdef SPIKE_MEM_WAIT_EN
      , W_WAIT
`endif
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_RESP
`ifdef SPIKE_MEM_WAIT_EN
      , R_WAIT
`endif
   } r_state_e;

   logic [AXI_DATA_WIDTH-1:0] mem [Words];

   w_state_e                  w_state_q, w_state_d;
   r_state_e                  r_state_q, r_state_d;
   logic                      awready_q, wready_q, arready_q;
   logic [7:0]                awid_q;
   logic [IdxW-1:0]           awidx_q;
   logic [1:0]                awsize_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [AXI_MASK_WIDTH-1:0] wstrb_q;
   logic                      wlast_q;
   logic [7:0]                bid_q, rid_q;
   logic                      bresp_q, rresp_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q;
`ifdef SPIKE_MEM_WAIT_EN
   logic [3:0]                w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`endif

   logic                      aw_hs, w_hs, ar_hs, commit, commit_ok;
   logic [IdxW-1:0]           commit_idx;
   logic [7:0]                commit_id;
   logic [1:0]                commit_size;
   logic [AXI_DATA_WIDTH-1:0] commit_data;
   logic [AXI_MASK_WIDTH-1:0] commit_strb;
   logic                      commit_last;
   logic                      unused_sig;

   assign aw_hs = CPUNC_AWVALID & awready_q;
   assign w_hs  = CPUNC_WVALID & wready_q;
   assign ar_hs = CPUNC_ARVALID & arready_q;

   // Whichever half arrived earlier comes from its latch, the other straight from the bus.
   assign commit_idx  = (w_state_q == W_HAVE_A) ? awidx_q : CPUNC_AWADDR[MEM_POWER_SIZE-1:2];
   assign commit_id   = (w_state_q == W_HAVE_A) ? awid_q : CPUNC_AWID;
   assign commit_size = (w_state_q == W_HAVE_A) ? awsize_q : CPUNC_AWSIZE;
   assign commit_data = (w_state_q == W_HAVE_D) ? wdata_q : CPUNC_WDATA;
   assign commit_strb = (w_state_q == W_HAVE_D) ? wstrb_q : CPUNC_WSTRB;
   assign commit_last = (w_state_q == W_HAVE_D) ? wlast_q : CPUNC_WLAST;
   assign commit_ok   = (commit_size == 2'b10) && commit_last;

   assign unused_sig = ^{CPUNC_AWADDR, CPUNC_ARADDR, 4'(WAIT_CYCLES)};

   // Write FSM next state: commit fires on the edge that accepts the second half.
   always_comb begin
      w_state_d = w_state_q;
      commit    = 1'b0;
`ifdef SPIKE_MEM_WAIT_EN
      w_cnt_d   = w_cnt_q;
`endif
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) commit = 1'b1;
            else if (aw_hs)    w_state_d = W_HAVE_A;
            else if (w_hs)     w_state_d = W_HAVE_D;
         end
         W_HAVE_A: if (w_hs)  commit = 1'b1;
         W_HAVE_D: if (aw_hs) commit = 1'b1;
`ifdef SPIKE_MEM_WAIT_EN
         W_WAIT: begin
            if (w_cnt_q == 4'd0) w_state_d = W_RESP;
            else                 w_cnt_d   = w_cnt_q - 4'd1;
         end
`endif
         W_RESP: if (CPUNC_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      if (commit) begin
`ifdef SPIKE_MEM_WAIT_EN
         w_state_d = (WAIT_CYCLES == 0) ? W_RESP : W_WAIT;
         w_cnt_d   = 4'(WAIT_CYCLES - 1);
`else
         w_state_d = W_RESP;
`endif
      end
   end

   // Read FSM next state: data is captured on the AR handshake and held until RREADY.
   always_comb begin
      r_state_d = r_state_q;
`ifdef SPIKE_MEM_WAIT_EN
      r_cnt_d   = r_cnt_q;
`endif
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
`ifdef SPIKE_MEM_WAIT_EN
               r_state_d = (WAIT_CYCLES == 0) ? R_RESP : R_WAIT;
               r_cnt_d   = 4'(WAIT_CYCLES - 1);
`else
               r_state_d = R_RESP;
`endif
            end
         end
`ifdef SPIKE_MEM_WAIT_EN
         R_WAIT: begin
            if (r_cnt_q == 4'd0) r_state_d = R_RESP;
            else                 r_cnt_d   = r_cnt_q - 4'd1;
         end
`endif
         R_RESP: if (CPUNC_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // State, registered READYs and captured transaction fields.
   always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
      if (CPUNC_ARESET) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         awid_q    <= '0;
         awidx_q   <= '0;
         awsize_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wlast_q   <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= 1'b0;
         rdata_q   <= '0;
`ifdef SPIKE_MEM_WAIT_EN
         w_cnt_q   <= '0;
         r_cnt_q   <= '0;
`endif
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
         wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
         arready_q <= (r_state_d == R_IDLE);
`ifdef SPIKE_MEM_WAIT_EN
         w_cnt_q   <= w_cnt_d;
         r_cnt_q   <= r_cnt_d;
`endif
         if (aw_hs) begin
            awid_q   <= CPUNC_AWID;
            awidx_q  <= CPUNC_AWADDR[MEM_POWER_SIZE-1:2];
            awsize_q <= CPUNC_AWSIZE;
         end
         if (w_hs) begin
            wdata_q <= CPUNC_WDATA;
            wstrb_q <= CPUNC_WSTRB;
            wlast_q <= CPUNC_WLAST;
         end
         if (commit) begin
            bid_q   <= commit_id;
            bresp_q <= !commit_ok;
         end
         if (ar_hs) begin
            rid_q   <= CPUNC_ARID;
            rresp_q <= (CPUNC_ARSIZE != 2'b10);
            // Sampled before this edge's write lands, so a same-edge write returns old data.
            rdata_q <= (CPUNC_ARSIZE == 2'b10) ? mem[CPUNC_ARADDR[MEM_POWER_SIZE-1:2]] : '0;
         end
      end
   end

   // Storage array: not reset, so contents survive CPUNC_ARESET.
   always_ff @(posedge CPUNC_ACLK) begin
      if (commit && commit_ok) begin
         for (int i = 0; i < int'(AXI_MASK_WIDTH); i++) begin
            if (commit_strb[i]) mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
         end
      end
   end

   assign CPUNC_AWREADY = awready_q;
   assign CPUNC_WREADY  = wready_q;
   assign CPUNC_ARREADY = arready_q;
   assign CPUNC_BVALID  = (w_state_q == W_RESP);
   assign CPUNC_BID     = bid_q;
   assign CPUNC_BRESP   = bresp_q;
   assign CPUNC_RVALID  = (r_state_q == R_RESP);
   assign CPUNC_RLAST   = CPUNC_RVALID;
   assign CPUNC_RID     = rid_q;
   assign CPUNC_RRESP   = rresp_q;
   assign CPUNC_RDATA   = rdata_q;

endmodule
